// File: rtl/pow8_pkg.sv
// Shared types and helpers for the eighth-root decode pipeline.
// Holds the stage bundle and the squaring-chain pow8 function.
package pow8_pkg;

  localparam int DATA_W = 32;
  localparam int ROOT_W = 4;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] value;
    logic [ROOT_W-1:0] partial;
  } stage_t;

  function automatic logic [DATA_W-1:0] pow8(
    input logic [ROOT_W-1:0] x
  );
    logic [7:0]  sq1;
    logic [15:0] sq2;
    logic [31:0] sq3;
    sq1 = 8'(x) * 8'(x);
    sq2 = 16'(sq1) * 16'(sq1);
    sq3 = 32'(sq2) * 32'(sq2);
    return sq3;
  endfunction

endpackage

// File: rtl/pow8_root_stage.sv
// One binary-search step of the eighth-root decoder.
// Tries bit K on top of the incoming partial root.
module pow8_root_stage
  import pow8_pkg::*;
#(
  parameter int K = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  localparam logic [ROOT_W-1:0] BIT_K = ROOT_W'(1) << K;

  logic [ROOT_W-1:0] cand;
  logic              keep;
  stage_t            nxt;

  always_comb begin
    cand = d.partial | BIT_K;
    keep = pow8(cand) <= d.value;
    nxt  = d;
    if (keep) nxt.partial = cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/pow8_root_pipe.sv
// Pipelined floor(value^(1/8)) decoder with exact flag.
// Single global enable stalls every stage on output backpressure.
module pow8_root_pipe
  import pow8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ROOT_W-1:0] out_root,
  output logic              out_exact,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  logic   en;
  logic   exact_d;
  stage_t chain [0:ROOT_W];
  stage_t last;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign chain[0] = {in_valid, in_data, ROOT_W'(0)};

  // chain[i] feeds the stage deciding bit ROOT_W-1-i
  for (genvar gi = 0; gi < ROOT_W; gi++) begin : g_stage
    pow8_root_stage #(
      .K(ROOT_W - 1 - gi)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .d    (chain[gi]),
      .q    (chain[gi+1])
    );
  end

  assign last    = chain[ROOT_W];
  assign exact_d = pow8(last.partial) == last.value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_root  <= '0;
      out_exact <= 1'b0;
    end else if (en) begin
      out_valid <= last.valid;
      if (last.valid) begin
        out_root  <= last.partial;
        out_exact <= exact_d;
      end
    end
  end

  always_comb begin
    busy = out_valid;
    for (int i = 1; i <= ROOT_W; i++) begin
      busy = busy | chain[i].valid;
    end
  end

endmodule
